if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage of the five-stage pipelined RV32 core.
- Owns the program counter and drives the address of the combinational-read instruction memory.
- Captures the returned instruction word, together with its PC and PC+4, into the IF/ID pipeline register for decode.
- Honours stall and flush requests from the hazard unit and branch/jump redirects from execute.
- Holds a redirect that arrives while fetch is stalled, so it is never lost.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted into IF/ID on flush or reset.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall_f  input  1  hold PC (from hazard unit)
stall_d  input  1  hold IF/ID register
flush_d  input  1  replace IF/ID contents with bubble
pc_src_e  input  1  redirect request from execute (taken branch / jal / jalr)
pc_target_e  input  32  redirect target address
imem_addr  output  32  instruction memory address (= current PC)
imem_rd  input  32  instruction word returned combinationally by instruction memory
instr_d  output  32  IF/ID instruction
pc_d  output  32  IF/ID PC of instr_d
pc_plus4_d  output  32  IF/ID PC+4 of instr_d
valid_d  output  1  IF/ID holds a real fetched instruction (0 = bubble)

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high. Reset overrides stall, flush and redirect in the same cycle.
- Reset values:
  - pc_f = RESET_PC
  - instr_d = NOP_INSTR
  - pc_d = 0, pc_plus4_d = 0, valid_d = 0
  - pending redirect cleared (pend_valid = 0, pend_target = 0)
- Address path: imem_addr = pc_f, purely combinational, with zero-cycle latency. imem_rd is sampled into IF/ID in the same cycle.
- Alignment: pc_f[1:0] is always 2'b00. pc_target_e[1:0] is ignored, and the target is forced to word alignment.
- PC+4 arithmetic: 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- Next-PC selection, highest priority first:
  1. pc_src_e=1 -> {pc_target_e[31:2],2'b00}
  2. pend_valid=1 -> pend_target
  3. otherwise -> pc_f+4
- PC register:
  - stall_f=0: pc_f <= next-PC, and pend_valid <= 0.
  - stall_f=1: pc_f holds.
- Pending redirect (two states, IDLE and PENDING):
  - IDLE -> PENDING when stall_f=1 and pc_src_e=1; latch the aligned target into pend_target.
  - In PENDING, a new pc_src_e with stall_f=1 overwrites pend_target (newest wins).
  - PENDING -> IDLE on the first cycle with stall_f=0; pc_f loads the target then, or the live pc_src_e target if that is asserted simultaneously.
- IF/ID register, flush over stall:
  - flush_d=1: instr_d <= NOP_INSTR, pc_d <= 0, pc_plus4_d <= 0, valid_d <= 0.
  - Else stall_d=0: instr_d <= imem_rd, pc_d <= pc_f, pc_plus4_d <= pc_f+4, valid_d <= 1.
  - Else: all IF/ID outputs hold.
- The block never self-flushes on pc_src_e. Squashing wrong-path instructions is the hazard unit's job via flush_d.
- stall_f and stall_d are independent. Any combination is legal and must follow the rules above exactly.

Test Plan:
- Reset then free-run: reset high 2 cycles, release, memory holds instr k at word k -> imem_addr sequence 0,4,8,12. instr_d lags one cycle with pc_d = 0,4,8 and valid_d=1 from the first edge after release.
- Stall: assert stall_f=stall_d=1 for 3 cycles while pc_f=8 -> imem_addr stays 8, instr_d/pc_d stay at word 1/4. On release, fetch resumes at 8 then 12 with no skip or duplicate.
- Redirect with flush: at pc_f=16 assert pc_src_e=1, pc_target_e=32'h0000_0042, flush_d=1 for one cycle -> next imem_addr=32'h0000_0040. instr_d=32'h0000_0013, valid_d=0, pc_d=0.
- Redirect during stall: stall_f=1, pc_src_e=1 with target 32'h100 for one cycle, then pc_src_e=0, stall held 2 more cycles -> imem_addr holds. On the first unstalled edge, pc_f=32'h100, then 32'h104.
- Flush beats stall, and reset beats all: flush_d=stall_d=1 -> bubble loaded. Then reset=1 together with stall_f=1 and pc_src_e=1 -> pc_f=RESET_PC, pend cleared, valid_d=0.
- Wrap: force redirect to 32'hFFFF_FFFC with stall_d=0 -> pc_plus4_d=32'h0000_0000 and next imem_addr=32'h0000_0000.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address,
// and captures {instr, pc, pc+4} into the IF/ID register. A redirect that
// arrives while fetch is stalled is parked until the stall releases.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } pend_state_t;

    pend_state_t state_q, state_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] instr_q, pc_id_q, pc_plus4_id_q;
    logic        valid_q;

    logic [31:0] target_aligned;
    logic [31:0] pc_plus4_f;
    logic        unused_target_lsbs;

    // Low target bits are architecturally meaningless for word fetch.
    assign unused_target_lsbs = ^pc_target_e[1:0];

    assign target_aligned = {pc_target_e[31:2], 2'b00};
    assign pc_plus4_f     = pc_f_q + 32'd4;
    assign imem_addr      = pc_f_q;

    assign instr_d    = instr_q;
    assign pc_d       = pc_id_q;
    assign pc_plus4_d = pc_plus4_id_q;
    assign valid_d    = valid_q;

    // Next PC: live redirect beats a parked redirect, which beats sequential fetch.
    always_comb begin
        pc_f_d = pc_f_q;
        if (!stall_f) begin
            if (pc_src_e) begin
                pc_f_d = target_aligned;
            end else if (state_q == PENDING) begin
                pc_f_d = pend_target_q;
            end else begin
                pc_f_d = pc_plus4_f;
            end
        end
    end

    // Pending-redirect FSM: park redirects seen under stall, newest wins.
    always_comb begin
        state_d       = state_q;
        pend_target_d = pend_target_q;
        case (state_q)
            IDLE: begin
                if (stall_f && pc_src_e) begin
                    state_d       = PENDING;
                    pend_target_d = target_aligned;
                end
            end
            PENDING: begin
                if (!stall_f) begin
                    state_d = IDLE;
                end else if (pc_src_e) begin
                    pend_target_d = target_aligned;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // PC and pending-redirect state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q        <= {RESET_PC[31:2], 2'b00};
            state_q       <= IDLE;
            pend_target_q <= 32'd0;
        end else begin
            pc_f_q        <= pc_f_d;
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
        end
    end

    // IF/ID register: flush inserts a bubble and takes priority over stall.
    always_ff @(posedge clk) begin
        if (reset || flush_d) begin
            instr_q       <= NOP_INSTR;
            pc_id_q       <= 32'd0;
            pc_plus4_id_q <= 32'd0;
            valid_q       <= 1'b0;
        end else if (!stall_d) begin
            instr_q       <= imem_rd;
            pc_id_q       <= pc_f_q;
            pc_plus4_id_q <= pc_plus4_f;
            valid_q       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run against a
// cycle-level reference model of the fetch rules.
module tb_if_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e, imem_addr, imem_rd, instr_d, pc_d, pc_plus4_d;
    logic        valid_d;

    int errors = 0;
    int checks = 0;

    // Reference model state
    longint unsigned m_pc;
    bit              m_pend;
    longint unsigned m_pend_t;
    logic [31:0]     m_instr, m_pcd, m_pc4d;
    bit              m_valid;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) ^ 32'hC0DE_0000;
    endfunction

    assign imem_rd = mem_word(imem_addr);

    if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .instr_d(instr_d),
        .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
    );

    // Advance one clock; the model applies the fetch rules to the inputs
    // that were present before the edge. Outputs are sampled 1 time unit after.
    task automatic tick();
        longint unsigned nxt, tgt;
        tgt = longint'(pc_target_e) & 64'hFFFF_FFFC;
        if (pc_src_e)    nxt = tgt;
        else if (m_pend) nxt = m_pend_t;
        else             nxt = (m_pc + 4) % 64'h1_0000_0000;
        if (reset) begin
            m_pc = RESET_PC; m_pend = 0; m_pend_t = 0;
            m_instr = NOP_INSTR; m_pcd = 0; m_pc4d = 0; m_valid = 0;
        end else begin
            if (flush_d) begin
                m_instr = NOP_INSTR; m_pcd = 0; m_pc4d = 0; m_valid = 0;
            end else if (!stall_d) begin
                m_instr = mem_word(m_pc[31:0]);
                m_pcd   = m_pc[31:0];
                m_pc4d  = 32'((m_pc + 4) % 64'h1_0000_0000);
                m_valid = 1;
            end
            if (!stall_f) begin
                m_pc = nxt; m_pend = 0;
            end else if (pc_src_e) begin
                m_pend = 1; m_pend_t = tgt;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        checks++;
        if ({imem_addr, instr_d, pc_d, pc_plus4_d, valid_d} !== {RESET_PC, NOP_INSTR, 32'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: addr=%h instr=%h pc_d=%h pc4=%h valid=%b, want %h %h 0 0 0",
                     imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, RESET_PC, NOP_INSTR);
        end
    endtask

    task automatic test_freerun();
        reset = 0;
        checks++;
        if (imem_addr !== 32'd0) begin
            errors++; $display("FAIL freerun_addr0: got %h want 0", imem_addr);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (imem_addr !== 32'(4 * (k + 1)) || pc_d !== 32'(4 * k) || valid_d !== 1'b1 ||
                instr_d !== mem_word(32'(4 * k)) || pc_plus4_d !== 32'(4 * k + 4)) begin
                errors++;
                $display("FAIL freerun_%0d: addr=%h pc_d=%h pc4=%h instr=%h valid=%b want addr=%h pc_d=%h",
                         k, imem_addr, pc_d, pc_plus4_d, instr_d, valid_d, 4 * (k + 1), 4 * k);
            end
        end
    endtask

    task automatic test_stall();
        stall_f = 1; stall_d = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (imem_addr !== 32'd8 || pc_d !== 32'd4 || instr_d !== mem_word(32'd4)) begin
                errors++;
                $display("FAIL stall_hold_%0d: addr=%h pc_d=%h instr=%h want 8 4 %h",
                         k, imem_addr, pc_d, instr_d, mem_word(32'd4));
            end
        end
        stall_f = 0; stall_d = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (imem_addr !== 32'(12 + 4 * k) || pc_d !== 32'(8 + 4 * k) || valid_d !== 1'b1) begin
                errors++;
                $display("FAIL stall_resume_%0d: addr=%h pc_d=%h valid=%b want %h %h 1",
                         k, imem_addr, pc_d, valid_d, 12 + 4 * k, 8 + 4 * k);
            end
        end
    endtask

    task automatic test_redirect_flush();
        pc_src_e = 1; pc_target_e = 32'h0000_0042; flush_d = 1;
        tick();
        pc_src_e = 0; flush_d = 0;
        checks++;
        if (imem_addr !== 32'h40 || instr_d !== NOP_INSTR || valid_d !== 1'b0 || pc_d !== 32'd0) begin
            errors++;
            $display("FAIL redirect_flush: addr=%h instr=%h valid=%b pc_d=%h want 40 %h 0 0",
                     imem_addr, instr_d, valid_d, pc_d, NOP_INSTR);
        end
    endtask

    task automatic test_redirect_stalled();
        stall_f = 1; pc_src_e = 1; pc_target_e = 32'h0000_0100;
        tick();
        pc_src_e = 0;
        tick(); tick();
        checks++;
        if (imem_addr !== 32'h40) begin
            errors++; $display("FAIL redirect_stalled_hold: addr=%h want 40", imem_addr);
        end
        stall_f = 0;
        tick();
        checks++;
        if (imem_addr !== 32'h100) begin
            errors++; $display("FAIL redirect_stalled_take: addr=%h want 100", imem_addr);
        end
        tick();
        checks++;
        if (imem_addr !== 32'h104 || pc_d !== 32'h100) begin
            errors++; $display("FAIL redirect_stalled_next: addr=%h pc_d=%h want 104 100", imem_addr, pc_d);
        end
    endtask

    task automatic test_priority();
        flush_d = 1; stall_d = 1;
        tick();
        flush_d = 0; stall_d = 0;
        checks++;
        if (instr_d !== NOP_INSTR || valid_d !== 1'b0 || pc_d !== 32'd0) begin
            errors++; $display("FAIL flush_over_stall: instr=%h valid=%b pc_d=%h want %h 0 0",
                               instr_d, valid_d, pc_d, NOP_INSTR);
        end
        reset = 1; stall_f = 1; pc_src_e = 1; pc_target_e = 32'h0000_0800;
        tick();
        checks++;
        if (imem_addr !== RESET_PC || valid_d !== 1'b0 || instr_d !== NOP_INSTR) begin
            errors++; $display("FAIL reset_over_all: addr=%h valid=%b instr=%h want %h 0 %h",
                               imem_addr, valid_d, instr_d, RESET_PC, NOP_INSTR);
        end
        idle_inputs();
        tick();
        checks++;
        if (imem_addr !== RESET_PC + 32'd4) begin
            errors++; $display("FAIL reset_clears_pend: addr=%h want %h", imem_addr, RESET_PC + 32'd4);
        end
    endtask

    task automatic test_wrap();
        pc_src_e = 1; pc_target_e = 32'hFFFF_FFFE;
        tick();
        pc_src_e = 0;
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_target: addr=%h want fffffffc", imem_addr);
        end
        tick();
        checks++;
        if (pc_d !== 32'hFFFF_FFFC || pc_plus4_d !== 32'd0 || imem_addr !== 32'd0) begin
            errors++; $display("FAIL wrap_plus4: pc_d=%h pc4=%h addr=%h want fffffffc 0 0",
                               pc_d, pc_plus4_d, imem_addr);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset       = ($urandom_range(0, 49) == 0);
            stall_f     = ($urandom_range(0, 2) == 0);
            stall_d     = ($urandom_range(0, 2) == 0);
            flush_d     = ($urandom_range(0, 5) == 0);
            pc_src_e    = ($urandom_range(0, 4) == 0);
            pc_target_e = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC | 32'($urandom_range(0, 3))
                                                      : $urandom;
            tick();
            checks++;
            if ({imem_addr, instr_d, pc_d, pc_plus4_d, valid_d} !==
                {m_pc[31:0], m_instr, m_pcd, m_pc4d, m_valid}) begin
                errors++;
                $display("FAIL random_%0d: addr=%h instr=%h pc_d=%h pc4=%h v=%b want %h %h %h %h %b",
                         c, imem_addr, instr_d, pc_d, pc_plus4_d, valid_d,
                         m_pc[31:0], m_instr, m_pcd, m_pc4d, m_valid);
            end
        end
    endtask

    initial begin
        m_pc = 0; m_pend = 0; m_pend_t = 0;
        m_instr = NOP_INSTR; m_pcd = 0; m_pc4d = 0; m_valid = 0;
        idle_inputs();
        #1;
        test_reset();
        test_freerun();
        test_stall();
        test_redirect_flush();
        test_redirect_stalled();
        test_priority();
        test_wrap();
        idle_inputs();
        reset = 1;
        tick();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
